dice_roller: RTL and testbench

//  Downstream consumer of the 3-bit LFSR rand_generator. Converts its q[3:1]

---
 rtl/dice_roller.sv | 163 ++++++++++++++++
 tb/tb_dice_roller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roller.sv
// Dice roller: turns the 3-bit LFSR stream from rand_generator into a fair
// 1..6 die face. A roll request runs a timed "tumbling" animation. It then
// settles on the first acceptable sample. Owns the generator's load line and
// reseeds it when the stream looks stuck.
module dice_roller #(
    parameter int unsigned ROLL_DIV    = 4,
    parameter int unsigned ROLL_STEPS  = 8,
    parameter int unsigned STUCK_LIMIT = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:1]       rnd,
    input  logic             roll,
    output logic             load,
    output logic [2:0]       value,
    output logic             valid,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] roll_count
);

    localparam int unsigned DivW  = (ROLL_DIV > 1) ? $clog2(ROLL_DIV) : 1;
    localparam int unsigned StepW = (ROLL_STEPS > 1) ? $clog2(ROLL_STEPS) : 1;
    localparam int unsigned RejW  = (STUCK_LIMIT > 1) ? $clog2(STUCK_LIMIT) : 1;

    localparam logic [DivW-1:0]  DivMax  = DivW'(ROLL_DIV - 1);
    localparam logic [StepW-1:0] StepMax = StepW'(ROLL_STEPS - 1);
    localparam logic [RejW-1:0]  RejMax  = RejW'(STUCK_LIMIT - 1);

    typedef enum logic [2:0] {StInit, StIdle, StRoll, StSettle, StDone} state_e;

    state_e             state_q, state_d;
    logic               roll_q;
    logic [DivW-1:0]    div_q, div_d;
    logic [StepW-1:0]   step_q, step_d;
    logic [RejW-1:0]    rej_q, rej_d;
    logic               load_q, load_d;
    logic [2:0]         value_q, value_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic rose;
    logic rnd_ok;

    assign rose   = roll & ~roll_q;
    // 0 and 7 are discarded so the remaining six codes map 1:1 onto die faces
    assign rnd_ok = (rnd != 3'd0) && (rnd != 3'd7);

    // Next-state and registered-output computation for the roll sequencer
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        step_d  = step_q;
        rej_d   = rej_q;
        load_d  = load_q;
        value_d = value_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            StInit: begin
                // load has been high for one clock; let the generator run
                load_d  = 1'b0;
                state_d = StIdle;
            end
            StIdle, StDone: begin
                if (rose) begin
                    state_d = StRoll;
                    div_d   = '0;
                    step_d  = '0;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                end
            end
            StRoll: begin
                if (div_q == DivMax) begin
                    div_d = '0;
                    // Animation frame: show the sample but do not mark it final
                    if (rnd_ok) begin
                        value_d = rnd;
                    end
                    if (step_q == StepMax) begin
                        step_d  = '0;
                        rej_d   = '0;
                        state_d = StSettle;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StSettle: begin
                if (rnd_ok) begin
                    value_d = rnd;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    err_d   = 1'b0;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    state_d = StDone;
                end else if (rej_q == RejMax) begin
                    // Generator appears locked up: reseed it and abandon the roll
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                    load_d  = 1'b1;
                    rej_d   = '0;
                    state_d = StInit;
                end else begin
                    rej_d = rej_q + 1'b1;
                end
            end
            default: begin
                state_d = StInit;
                load_d  = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs; roll_q samples the request every clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StInit;
            roll_q  <= 1'b0;
            div_q   <= '0;
            step_q  <= '0;
            rej_q   <= '0;
            load_q  <= 1'b1;
            value_q <= 3'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            roll_q  <= roll;
            div_q   <= div_d;
            step_q  <= step_d;
            rej_q   <= rej_d;
            load_q  <= load_d;
            value_q <= value_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign load       = load_q;
    assign value      = value_q;
    assign valid      = valid_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign roll_count = cnt_q;

endmodule

// File: tb/tb_dice_roller.sv
// Directed testbench for dice_roller: reset, single roll latency, stuck
// reseed, held/ignored requests, mid-roll reset and an LFSR-driven soak.
module tb_dice_roller;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       roll     = 1'b0;
    logic [3:1] rnd_drv  = 3'd0;
    logic       use_lfsr = 1'b0;
    logic [3:1] lfsr     = 3'b001;
    logic [3:1] rnd;

    logic       load, valid, busy, err;
    logic [2:0] value;
    logic [7:0] roll_count;

    logic       load2, valid2, busy2, err2;
    logic [2:0] value2;
    logic [1:0] roll_count2;

    int errors = 0;
    int checks = 0;

    assign rnd = use_lfsr ? lfsr : rnd_drv;

    always #5 clk = ~clk;

    // Stand-in 3-bit maximal LFSR (never 0), seeded whenever load is high
    always @(posedge clk) begin
        if (load) lfsr <= 3'b001;
        else      lfsr <= {lfsr[2], lfsr[1], lfsr[3] ^ lfsr[2]};
    end

    dice_roller dut (
        .clk        (clk),
        .reset      (reset),
        .rnd        (rnd),
        .roll       (roll),
        .load       (load),
        .value      (value),
        .valid      (valid),
        .busy       (busy),
        .err        (err),
        .roll_count (roll_count)
    );

    dice_roller #(.CNT_W(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .rnd        (rnd),
        .roll       (roll),
        .load       (load2),
        .value      (value2),
        .valid      (valid2),
        .busy       (busy2),
        .err        (err2),
        .roll_count (roll_count2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        roll = 1'b1;
        tick();
        roll = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (load !== 1'b1) begin errors++; $display("FAIL reset_load got=%b exp=1", load); end
        checks++; if (value !== 3'd0) begin errors++; $display("FAIL reset_value got=%0d exp=0", value); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (roll_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", roll_count); end
        reset = 1'b0;
        #1;
        checks++; if (load !== 1'b1) begin errors++; $display("FAIL init_load got=%b exp=1", load); end
        tick();
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL idle_load got=%b exp=0", load); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        rnd_drv = 3'd5;
        pulse();
        for (int i = 0; i < 33; i++) begin
            checks++;
            if (busy !== 1'b1 || valid !== 1'b0) begin
                errors++;
                $display("FAIL single_busy cyc=%0d got busy=%b valid=%b exp busy=1 valid=0", i, busy, valid);
            end
            tick();
        end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", valid); end
        checks++; if (value !== 3'd5) begin errors++; $display("FAIL single_value got=%0d exp=5", value); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b exp=0", busy); end
        checks++; if (roll_count !== 8'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", roll_count); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err got=%b exp=0", err); end
    endtask

    task automatic test_stuck();
        do_reset();
        rnd_drv = 3'd7;
        pulse();
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (busy !== 1'b1 || err !== 1'b0 || value !== 3'd0 || load !== 1'b0) begin
                errors++;
                $display("FAIL stuck_run cyc=%0d got busy=%b err=%b value=%0d load=%b exp 1 0 0 0",
                         i, busy, err, value, load);
            end
            tick();
        end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL stuck_err got=%b exp=1", err); end
        checks++; if (load !== 1'b1) begin errors++; $display("FAIL stuck_load got=%b exp=1", load); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stuck_busy got=%b exp=0", busy); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stuck_valid got=%b exp=0", valid); end
        tick();
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL stuck_load_end got=%b exp=0", load); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL stuck_err_sticky got=%b exp=1", err); end
        rnd_drv = 3'd3;
        pulse();
        repeat (33) tick();
        checks++; if (value !== 3'd3) begin errors++; $display("FAIL recover_value got=%0d exp=3", value); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL recover_valid got=%b exp=1", valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL recover_err got=%b exp=0", err); end
        checks++; if (roll_count !== 8'd1) begin errors++; $display("FAIL recover_count got=%0d exp=1", roll_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        rnd_drv = 3'd2;
        roll = 1'b1;
        repeat (100) tick();
        checks++; if (roll_count !== 8'd1) begin errors++; $display("FAIL held_count got=%0d exp=1", roll_count); end
        checks++; if (valid !== 1'b1 || value !== 3'd2) begin errors++; $display("FAIL held_result got valid=%b value=%0d exp 1 2", valid, value); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_busy got=%b exp=0", busy); end
        roll = 1'b0;
        tick();
        pulse();
        checks++; if (valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL reroll_start got valid=%b busy=%b exp 0 1", valid, busy); end
        repeat (9) tick();
        pulse();
        repeat (23) tick();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL reroll_valid got=%b exp=1", valid); end
        checks++; if (roll_count !== 8'd2) begin errors++; $display("FAIL reroll_count got=%0d exp=2", roll_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reroll_busy got=%b exp=0", busy); end
        repeat (40) tick();
        checks++; if (roll_count !== 8'd2 || valid !== 1'b1) begin errors++; $display("FAIL no_queue got count=%0d valid=%b exp 2 1", roll_count, valid); end
    endtask

    task automatic test_reset_mid();
        rnd_drv = 3'd4;
        pulse();
        repeat (9) tick();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (load !== 1'b1) begin errors++; $display("FAIL mid_load got=%b exp=1", load); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if (value !== 3'd0) begin errors++; $display("FAIL mid_value got=%0d exp=0", value); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", valid); end
        checks++; if (roll_count !== 8'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", roll_count); end
        tick();
        tick();
        reset = 1'b0;
        tick();
        pulse();
        repeat (33) tick();
        checks++; if (value !== 3'd4 || valid !== 1'b1) begin errors++; $display("FAIL mid_after got value=%0d valid=%b exp 4 1", value, valid); end
        checks++; if (roll_count !== 8'd1) begin errors++; $display("FAIL mid_after_count got=%0d exp=1", roll_count); end
    endtask

    task automatic test_lfsr();
        use_lfsr = 1'b1;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            int w;
            pulse();
            w = 0;
            while (valid !== 1'b1 && w < 100) begin
                tick();
                w++;
            end
            checks++;
            if (valid !== 1'b1) begin errors++; $display("FAIL lfsr_timeout roll=%0d got valid=%b exp=1", k, valid); end
            checks++;
            if (value < 3'd1 || value > 3'd6 || err !== 1'b0) begin
                errors++;
                $display("FAIL lfsr_value roll=%0d got value=%0d err=%b exp 1..6 err=0", k, value, err);
            end
        end
        checks++; if (roll_count !== 8'd20) begin errors++; $display("FAIL lfsr_count got=%0d exp=20", roll_count); end
        checks++; if (roll_count2 !== 2'd3) begin errors++; $display("FAIL sat_count got=%0d exp=3", roll_count2); end
        checks++;
        if (err2 !== 1'b0 || valid2 !== 1'b1 || busy2 !== 1'b0 || load2 !== 1'b0 || value2 !== value) begin
            errors++;
            $display("FAIL sat_outputs got err=%b valid=%b busy=%b load=%b value=%0d exp 0 1 0 0 %0d",
                     err2, valid2, busy2, load2, value2, value);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_stuck();
        test_back_to_back();
        test_reset_mid();
        test_lfsr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
